tmds_encoder_8b10b: RTL and testbench

Pipelined DVI/HDMI TMDS channel encoder. Converts one 8-bit pixel component plus 2 control bits and data-enable per pixel clock into a 10-bit DC-balanced TMDS symbol. Sits directly upstream of the 10:1 serializer: `o_tmds` drives its 10-bit parallel input, and both blocks run on the same pixel clock. Three instances, one per colour channel, form the display output path.

---
 rtl/tmds_encoder_8b10b.sv | 91 +++++++++
 tb/tb_tmds_encoder_8b10b.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_8b10b.sv
// rtl/tmds_encoder_8b10b.sv - two-stage pipelined TMDS 8b/10b channel encoder
// Stage 1 picks XOR/XNOR transition minimisation; stage 2 DC-balances against running disparity.
module tmds_encoder_8b10b (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic       i_de,
  output logic [9:0] o_tmds,
  output logic [4:0] o_disp
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m;

  logic [8:0] s1_qm;
  logic       s1_de;
  logic [1:0] s1_ctrl;

  logic [3:0]        n1q;
  logic signed [4:0] diff;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_nxt;
  logic [9:0]        tmds_nxt;

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, i_data[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);
    q_m      = '0;
    q_m[0]   = i_data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ i_data[i]) : (q_m[i-1] ^ i_data[i]);
    q_m[8] = ~use_xnor;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_qm   <= '0;
      s1_de   <= 1'b0;
      s1_ctrl <= '0;
    end else begin
      s1_qm   <= q_m;
      s1_de   <= i_de;
      s1_ctrl <= i_ctrl;
    end
  end

  // diff = n1q - n0q = 2*n1q - 8, kept in 5-bit two's complement
  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, s1_qm[i]};
    diff = $signed({n1q, 1'b0}) - 5'sd8;
  end

  always_comb begin
    tmds_nxt = 10'h354;
    cnt_nxt  = 5'sd0;
    if (!s1_de) begin
      case (s1_ctrl)
        2'b00:   tmds_nxt = 10'h354;
        2'b01:   tmds_nxt = 10'h0AB;
        2'b10:   tmds_nxt = 10'h154;
        default: tmds_nxt = 10'h2AB;
      endcase
    end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      tmds_nxt = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
      cnt_nxt  = s1_qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      tmds_nxt = {1'b1, s1_qm[8], ~s1_qm[7:0]};
      cnt_nxt  = cnt + (s1_qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      tmds_nxt = {1'b0, s1_qm[8], s1_qm[7:0]};
      cnt_nxt  = cnt - (s1_qm[8] ? 5'sd0 : 5'sd2) + diff;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tmds <= 10'h354;
      cnt    <= 5'sd0;
    end else begin
      o_tmds <= tmds_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign o_disp = cnt;

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// tb/tb_tmds_encoder_8b10b.sv - directed and random self-checking bench for tmds_encoder_8b10b
module tb_tmds_encoder_8b10b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] ctrl = '0;
  logic       de = 1'b0;
  logic [9:0] tmds;
  logic [4:0] disp;

  int passed = 0;
  int total = 0;
  int mcnt = 0;
  logic [9:0] q_t[$];
  logic [4:0] q_d[$];

  tmds_encoder_8b10b dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_ctrl  (ctrl),
    .i_de    (de),
    .o_tmds  (tmds),
    .o_disp  (disp)
  );

  always #5 clk = ~clk;

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  // Reference encoder: integer disparity, encodes symbols in presentation order
  task automatic model_push(input logic mde, input logic [1:0] mctrl, input logic [7:0] md);
    logic [8:0] qm;
    logic [9:0] sym;
    logic       xn;
    int n1, n0;
    if (!mde) begin
      mcnt = 0;
      case (mctrl)
        2'd0:    sym = 10'h354;
        2'd1:    sym = 10'h0AB;
        2'd2:    sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end else begin
      xn = ($countones(md) > 4) || ($countones(md) == 4 && md[0] == 1'b0);
      qm[0] = md[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ md[i]) : (qm[i-1] ^ md[i]);
      qm[8] = !xn;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (mcnt == 0 || n1 == n0) begin
        sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        mcnt = mcnt + (qm[8] ? (n1 - n0) : (n0 - n1));
      end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
        sym = {1'b1, qm[8], ~qm[7:0]};
        mcnt = mcnt + (qm[8] ? 2 : 0) + n0 - n1;
      end else begin
        sym = {1'b0, qm[8], qm[7:0]};
        mcnt = mcnt - (qm[8] ? 0 : 2) + n1 - n0;
      end
    end
    q_t.push_back(sym);
    q_d.push_back(5'(mcnt));
  endtask

  task automatic model_reset();
    q_t.delete();
    q_d.delete();
    mcnt = 0;
    q_t.push_back(10'h354);
    q_d.push_back(5'd0);
  endtask

  task automatic cyc(input logic nde, input logic [1:0] nctrl, input logic [7:0] ndata);
    int sd;
    de = nde;
    ctrl = nctrl;
    data = ndata;
    model_push(nde, nctrl, ndata);
    @(posedge clk);
    #1;
    chk10("model_sym", tmds, q_t.pop_front());
    chk5("model_disp", disp, q_d.pop_front());
    sd = $signed(disp);
    total++;
    assert (sd >= -10 && sd <= 10) passed++;
    else $error("FAIL disp_range observed=%0d expected=-10..10", sd);
  endtask

  logic [9:0] bal_t[5] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100};
  logic [4:0] bal_d[5] = '{5'(-8), 5'd2, 5'(-6), 5'd4, 5'(-4)};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk10("rst_tmds", tmds, 10'h354);
    chk5("rst_disp", disp, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 2'd0, 8'h00);
    chk10("post_rst_tmds", tmds, 10'h354);
    cyc(1'b0, 2'd0, 8'h00);
    chk10("post_rst_tmds2", tmds, 10'h354);

    // control tokens
    cyc(1'b0, 2'd0, 8'h00);
    cyc(1'b0, 2'd1, 8'h00);
    chk10("ctrl00", tmds, 10'h354);
    cyc(1'b0, 2'd2, 8'h00);
    chk10("ctrl01", tmds, 10'h0AB);
    chk5("ctrl01_disp", disp, 5'd0);
    cyc(1'b0, 2'd3, 8'h00);
    chk10("ctrl10", tmds, 10'h154);
    cyc(1'b0, 2'd0, 8'h00);
    chk10("ctrl11", tmds, 10'h2AB);
    chk5("ctrl11_disp", disp, 5'd0);

    // balancing on a run of zeros
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'd0, 8'h00);
      if (i > 0) begin
        chk10("bal_tmds", tmds, bal_t[i-1]);
        chk5("bal_disp", disp, bal_d[i-1]);
      end
    end
    cyc(1'b0, 2'd0, 8'h00);
    chk10("bal_tmds_last", tmds, bal_t[4]);
    chk5("bal_disp_last", disp, bal_d[4]);

    // XNOR path
    cyc(1'b1, 2'd0, 8'hFF);
    cyc(1'b0, 2'd0, 8'h00);
    chk10("xnor_tmds", tmds, 10'h200);
    chk5("xnor_disp", disp, 5'(-8));

    // single-cycle control restarts disparity
    cyc(1'b1, 2'd0, 8'h00);
    cyc(1'b0, 2'd0, 8'h00);
    chk10("dr_tmds0", tmds, 10'h100);
    chk5("dr_disp0", disp, 5'(-8));
    cyc(1'b1, 2'd0, 8'h00);
    chk10("dr_tmds1", tmds, 10'h354);
    chk5("dr_disp1", disp, 5'd0);
    cyc(1'b0, 2'd0, 8'h00);
    chk10("dr_tmds2", tmds, 10'h100);
    chk5("dr_disp2", disp, 5'(-8));

    // asynchronous reset between edges
    cyc(1'b1, 2'd0, 8'h00);
    cyc(1'b1, 2'd0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk10("arst_tmds", tmds, 10'h354);
    chk5("arst_disp", disp, 5'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 2'd0, 8'h00);
    chk10("arst_flush", tmds, 10'h354);
    cyc(1'b0, 2'd0, 8'h00);
    chk10("arst_first", tmds, 10'h100);
    chk5("arst_first_disp", disp, 5'(-8));

    // random soak, mostly long data runs
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
